// File: rtl/swan_rho_pkg.sv
// Shared definitions for the folded SWAN rho column-mixing unit.
// Contents:
//   - derived-width helpers: side_size, column_size, k_count
//   - 2-bit FSM state encoding (ST_IDLE, ST_ACC, ST_APPLY, ST_DONE)
//   - configuration legality checks for BLOCK_SIZE / COLUMNS / LANES
package swan_rho_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ACC   = 2'd1;
  localparam state_t ST_APPLY = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  function automatic int unsigned side_size(input int unsigned block_size);
    return block_size / 2;
  endfunction

  function automatic int unsigned column_size(input int unsigned block_size,
                                              input int unsigned columns);
    return (block_size / 2) / columns;
  endfunction

  function automatic int unsigned k_count(input int unsigned columns,
                                          input int unsigned lanes);
    return columns / lanes;
  endfunction

  function automatic bit is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

  function automatic bit block_size_ok(input int unsigned block_size);
    return (block_size == 64) || (block_size == 128) || (block_size == 256);
  endfunction

  // Even power of two, at least 2, and dividing the half-block evenly.
  function automatic bit columns_ok(input int unsigned block_size,
                                    input int unsigned columns);
    return is_pow2(columns) && (columns >= 2) &&
           (((block_size / 2) % columns) == 0);
  endfunction

  function automatic bit lanes_ok(input int unsigned columns,
                                  input int unsigned lanes);
    return is_pow2(lanes) && (lanes <= columns) && ((columns % lanes) == 0);
  endfunction

endpackage

// File: rtl/rho_lane_xor.sv
// XOR-reduce LANES adjacent columns down to one column-wide word.
// Ports:
//   i_cols  in  LANES*COLUMN_SIZE  packed group of columns
//   o_t     out COLUMN_SIZE        bitwise XOR of all columns in the group
module rho_lane_xor #(
  parameter int unsigned LANES       = 4,
  parameter int unsigned COLUMN_SIZE = 8
) (
  input  logic [LANES*COLUMN_SIZE-1:0] i_cols,
  output logic [COLUMN_SIZE-1:0]       o_t
);

  always_comb begin
    o_t = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      o_t = o_t ^ i_cols[l*COLUMN_SIZE +: COLUMN_SIZE];
    end
  end

endmodule

// File: rtl/rho_folded.sv
// Folded rho layer: y[i] = x[i] ^ t, t = XOR of all columns of the half-block.
// LANES columns are processed per cycle: K cycles accumulate t, K cycles
// apply it in place, then the result is held in DONE until taken.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   input handshake for x (SIDE_SIZE bits, column 0 = MSBs)
//   out_valid/out_ready output handshake for y (same column ordering)
module rho_folded
  import swan_rho_pkg::*;
#(
  parameter int unsigned BLOCK_SIZE = 64,
  parameter int unsigned COLUMNS    = 4,
  parameter int unsigned LANES      = COLUMNS
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [side_size(BLOCK_SIZE)-1:0]  x,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [side_size(BLOCK_SIZE)-1:0]  y
);

  localparam int unsigned SIDE = side_size(BLOCK_SIZE);
  localparam int unsigned CS   = column_size(BLOCK_SIZE, COLUMNS);
  localparam int unsigned K    = k_count(COLUMNS, LANES);
  localparam int unsigned LW   = LANES * CS;
  localparam int unsigned CW   = $clog2(COLUMNS);

  // Column index of the last lane group in a phase.
  localparam logic [CW-1:0] COL_LAST = CW'(COLUMNS - LANES);
  // Counter step; wraps to 0 after the last group since COLUMNS is a power of two.
  localparam logic [CW-1:0] COL_STEP = CW'(LANES);

  if (!block_size_ok(BLOCK_SIZE)) begin : g_bad_block
    $error("rho_folded: BLOCK_SIZE must be 64, 128 or 256");
  end
  if (!columns_ok(BLOCK_SIZE, COLUMNS)) begin : g_bad_columns
    $error("rho_folded: COLUMNS must be an even power of two >= 2");
  end
  if (!lanes_ok(COLUMNS, LANES)) begin : g_bad_lanes
    $error("rho_folded: LANES must be a power of two dividing COLUMNS");
  end

  state_t          r_state;
  logic [SIDE-1:0] r_buf;
  logic [CS-1:0]   r_t;
  logic [CW-1:0]   r_col;

  logic [LW-1:0]   w_grp [K];
  logic [LW-1:0]   w_sel;
  logic [CS-1:0]   w_lane_t;
  logic            w_accept;

  // Lane group g covers columns g*LANES .. g*LANES+LANES-1, MSB-first.
  for (genvar g = 0; g < K; g++) begin : g_groups
    assign w_grp[g] = r_buf[SIDE-1-g*LW -: LW];
  end

  // Pick the group addressed by the column counter.
  always_comb begin
    w_sel = '0;
    for (int unsigned g = 0; g < K; g++) begin
      if (CW'(g * LANES) == r_col) begin
        w_sel = w_grp[g];
      end
    end
  end

  rho_lane_xor #(
    .LANES       (LANES),
    .COLUMN_SIZE (CS)
  ) u_lane_xor (
    .i_cols (w_sel),
    .o_t    (w_lane_t)
  );

  // DONE accepts a new block in the same cycle the result is taken.
  assign in_ready  = (r_state == ST_IDLE) || ((r_state == ST_DONE) && out_ready);
  assign out_valid = (r_state == ST_DONE);
  assign y         = r_buf;
  assign w_accept  = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_buf   <= '0;
      r_t     <= '0;
      r_col   <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_accept) begin
            r_buf   <= x;
            r_t     <= '0;
            r_col   <= '0;
            r_state <= ST_ACC;
          end else if (r_state == ST_DONE && out_ready) begin
            r_state <= ST_IDLE;
          end
        end
        ST_ACC: begin
          r_t   <= r_t ^ w_lane_t;
          r_col <= r_col + COL_STEP;
          if (r_col == COL_LAST) begin
            r_state <= ST_APPLY;
          end
        end
        ST_APPLY: begin
          for (int unsigned g = 0; g < K; g++) begin
            if (CW'(g * LANES) == r_col) begin
              r_buf[SIDE-1-g*LW -: LW] <= w_grp[g] ^ {LANES{r_t}};
            end
          end
          r_col <= r_col + COL_STEP;
          if (r_col == COL_LAST) begin
            r_state <= ST_DONE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rho_folded.sv
// Self-checking bench for rho_folded: three 64-bit instances (LANES 4, 1, 2)
// plus one 128-bit, 8-column, 2-lane instance driven with random traffic.
module tb_rho_folded;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Small instances: index 0 -> LANES=4, 1 -> LANES=1, 2 -> LANES=2
  logic        vld  [3];
  logic        ird  [3];
  logic [31:0] xin  [3];
  logic        ovld [3];
  logic        rdy  [3];
  logic [31:0] ys   [3];

  logic         b_vld, b_ird, b_ovld, b_ordy;
  logic [63:0]  b_x, b_y;

  rho_folded #(.BLOCK_SIZE(64), .COLUMNS(4), .LANES(4)) u_l4 (
    .clk(clk), .rst(rst), .in_valid(vld[0]), .in_ready(ird[0]), .x(xin[0]),
    .out_valid(ovld[0]), .out_ready(rdy[0]), .y(ys[0]));
  rho_folded #(.BLOCK_SIZE(64), .COLUMNS(4), .LANES(1)) u_l1 (
    .clk(clk), .rst(rst), .in_valid(vld[1]), .in_ready(ird[1]), .x(xin[1]),
    .out_valid(ovld[1]), .out_ready(rdy[1]), .y(ys[1]));
  rho_folded #(.BLOCK_SIZE(64), .COLUMNS(4), .LANES(2)) u_l2 (
    .clk(clk), .rst(rst), .in_valid(vld[2]), .in_ready(ird[2]), .x(xin[2]),
    .out_valid(ovld[2]), .out_ready(rdy[2]), .y(ys[2]));
  rho_folded #(.BLOCK_SIZE(128), .COLUMNS(8), .LANES(2)) u_big (
    .clk(clk), .rst(rst), .in_valid(b_vld), .in_ready(b_ird), .x(b_x),
    .out_valid(b_ovld), .out_ready(b_ordy), .y(b_y));

  // Golden model: t = XOR of all columns, then every column ^= t.
  function automatic logic [127:0] rho_ref(input logic [127:0] v,
                                           input int side, input int cols);
    int cs = side / cols;
    logic [127:0] m, t, r;
    m = (128'd1 << cs) - 128'd1;
    t = '0;
    for (int c = 0; c < cols; c++) t = t ^ ((v >> (c * cs)) & m);
    r = v;
    for (int c = 0; c < cols; c++) r = r ^ (t << (c * cs));
    return r;
  endfunction

  // Run one block through small instance d; lat counts edges from the
  // accepting edge (= 1) until out_valid is seen, or -1 on timeout.
  task automatic run_block(input int d, input logic [31:0] xv,
                           output logic [31:0] yv, output int lat);
    int n;
    n = 0;
    rdy[d] = 1'b1;
    while (!ird[d] && n < 50) begin @(posedge clk); #1; n++; end
    xin[d] = xv;
    vld[d] = 1'b1;
    @(posedge clk); #1;
    vld[d] = 1'b0;
    lat = 1;
    n = 0;
    while (!ovld[d] && n < 50) begin @(posedge clk); #1; lat++; n++; end
    if (!ovld[d]) lat = -1;
    yv = ys[d];
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin vld[d] = 0; rdy[d] = 0; xin[d] = '1; end
    b_vld = 0; b_ordy = 0; b_x = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      n_tests += 3;
      if (ird[d] !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready[%0d] got %b exp 1", d, ird[d]); end
      if (ovld[d] !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid[%0d] got %b exp 0", d, ovld[d]); end
      if (ys[d] !== 32'h0) begin n_fail++; $display("FAIL reset_y[%0d] got %h exp 0", d, ys[d]); end
    end
    n_tests += 3;
    if (b_ird !== 1'b1) begin n_fail++; $display("FAIL reset_big_in_ready got %b exp 1", b_ird); end
    if (b_ovld !== 1'b0) begin n_fail++; $display("FAIL reset_big_out_valid got %b exp 0", b_ovld); end
    if (b_y !== 64'h0) begin n_fail++; $display("FAIL reset_big_y got %h exp 0", b_y); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_latency;
    int exp_lat [3] = '{3, 9, 5};
    logic [31:0] yv;
    int lat;
    for (int d = 0; d < 3; d++) begin
      run_block(d, 32'h1234_5678, yv, lat);
      n_tests += 2;
      if (yv !== 32'h1A3C_5E70) begin n_fail++; $display("FAIL known_vector[%0d] got %h exp 1a3c5e70", d, yv); end
      if (lat !== exp_lat[d]) begin n_fail++; $display("FAIL latency[%0d] got %0d exp %0d", d, lat, exp_lat[d]); end
    end
  endtask

  task automatic test_involution;
    logic [31:0] y1, y2;
    int lat;
    run_block(0, 32'h1234_5678, y1, lat);
    run_block(0, y1, y2, lat);
    n_tests++;
    if (y2 !== 32'h1234_5678) begin n_fail++; $display("FAIL involution got %h exp 12345678", y2); end
  endtask

  task automatic test_corners;
    logic [31:0] yv;
    int lat;
    for (int d = 0; d < 3; d++) begin
      run_block(d, 32'h0000_0001, yv, lat);
      n_tests++;
      if (yv !== 32'h0101_0100) begin n_fail++; $display("FAIL one_bit[%0d] got %h exp 01010100", d, yv); end
      run_block(d, 32'hFFFF_FFFF, yv, lat);
      n_tests++;
      if (yv !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL all_ones[%0d] got %h exp ffffffff", d, yv); end
    end
  endtask

  task automatic test_random_small;
    logic [31:0] xv, yv;
    logic [127:0] e;
    int lat;
    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 8; i++) begin
        xv = $urandom();
        e = rho_ref({96'h0, xv}, 32, 4);
        run_block(d, xv, yv, lat);
        n_tests++;
        if (yv !== e[31:0]) begin n_fail++; $display("FAIL random_small[%0d] x=%h got %h exp %h", d, xv, yv, e[31:0]); end
      end
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] a, b;
    logic [127:0] ea, eb;
    int n;
    a = $urandom(); b = $urandom();
    ea = rho_ref({96'h0, a}, 32, 4);
    eb = rho_ref({96'h0, b}, 32, 4);
    rdy[0] = 1'b0;
    xin[0] = a; vld[0] = 1'b1;
    @(posedge clk); #1;
    xin[0] = b;                       // next block waits with valid held high
    n = 0;
    while (!ovld[0] && n < 20) begin @(posedge clk); #1; n++; end
    n_tests++;
    if (ovld[0] !== 1'b1) begin n_fail++; $display("FAIL bp_reach_done got %b exp 1", ovld[0]); end
    for (int i = 0; i < 5; i++) begin
      n_tests += 3;
      if (ovld[0] !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid c%0d got %b exp 1", i, ovld[0]); end
      if (ys[0] !== ea[31:0]) begin n_fail++; $display("FAIL bp_hold_y c%0d got %h exp %h", i, ys[0], ea[31:0]); end
      if (ird[0] !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready c%0d got %b exp 0", i, ird[0]); end
      @(posedge clk); #1;
    end
    rdy[0] = 1'b1;
    #1;
    n_tests++;
    if (ird[0] !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready got %b exp 1", ird[0]); end
    @(posedge clk); #1;
    vld[0] = 1'b0;
    n_tests += 2;
    if (ovld[0] !== 1'b0) begin n_fail++; $display("FAIL bp_taken_valid got %b exp 0", ovld[0]); end
    if (ird[0] !== 1'b0) begin n_fail++; $display("FAIL bp_busy_ready got %b exp 0", ird[0]); end
    n = 0;
    while (!ovld[0] && n < 20) begin @(posedge clk); #1; n++; end
    n_tests++;
    if (ys[0] !== eb[31:0] || ovld[0] !== 1'b1) begin
      n_fail++; $display("FAIL bp_second_block got %h valid %b exp %h", ys[0], ovld[0], eb[31:0]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_in_apply;
    logic [31:0] yv;
    int lat;
    rdy[1] = 1'b1;
    xin[1] = $urandom(); vld[1] = 1'b1;
    @(posedge clk); #1;               // accept edge
    vld[1] = 1'b0;
    repeat (5) begin @(posedge clk); #1; end  // 4 ACC edges + 1 APPLY edge
    n_tests++;
    if (ovld[1] !== 1'b0) begin n_fail++; $display("FAIL rst_apply_pre_valid got %b exp 0", ovld[1]); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_tests += 3;
    if (ovld[1] !== 1'b0) begin n_fail++; $display("FAIL rst_apply_valid got %b exp 0", ovld[1]); end
    if (ird[1] !== 1'b1) begin n_fail++; $display("FAIL rst_apply_ready got %b exp 1", ird[1]); end
    if (ys[1] !== 32'h0) begin n_fail++; $display("FAIL rst_apply_y got %h exp 0", ys[1]); end
    run_block(1, 32'h1234_5678, yv, lat);
    n_tests += 2;
    if (yv !== 32'h1A3C_5E70) begin n_fail++; $display("FAIL rst_apply_after got %h exp 1a3c5e70", yv); end
    if (lat !== 9) begin n_fail++; $display("FAIL rst_apply_latency got %0d exp 9", lat); end
  endtask

  task automatic test_random_128;
    logic [127:0] q [$];
    logic [127:0] e, pend;
    logic [63:0] ycap;
    int sent, got, cyc;
    bit acc, oacc;
    sent = 0; got = 0; cyc = 0;
    b_vld = 1'b0;
    while (got < 1000 && cyc < 40000) begin
      b_ordy = ($urandom_range(0, 3) != 0);
      if (!b_vld && sent < 1000 && $urandom_range(0, 3) != 0) begin
        b_x = {$urandom(), $urandom()};
        b_vld = 1'b1;
      end
      #1;
      acc  = b_vld && b_ird;
      oacc = b_ovld && b_ordy;
      ycap = b_y;
      @(posedge clk); #1;
      cyc++;
      if (oacc) begin
        n_tests++;
        if (q.size() == 0) begin
          n_fail++; $display("FAIL big_extra_output got %h exp none", ycap);
        end else begin
          pend = q.pop_front();
          e = rho_ref(pend, 64, 8);
          if (ycap !== e[63:0]) begin
            n_fail++; $display("FAIL big_block%0d got %h exp %h", got, ycap, e[63:0]);
          end
        end
        got++;
      end
      if (acc) begin
        q.push_back({64'h0, b_x});
        sent++;
        b_vld = 1'b0;
      end
    end
    b_vld = 1'b0; b_ordy = 1'b0;
    n_tests += 2;
    if (got != 1000) begin n_fail++; $display("FAIL big_count got %0d exp 1000", got); end
    if (q.size() != 0) begin n_fail++; $display("FAIL big_leftover got %0d exp 0", q.size()); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_involution();
    test_corners();
    test_random_small();
    test_backpressure();
    test_reset_in_apply();
    test_random_128();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rho_folded.md
# rho_folded

Folded, parametrised successor to the SWAN rho column-mixing layer: computes y[i] = a[i] ^ t with t = XOR of all columns of one half-block. It processes LANES columns per cycle over a valid/ready handshake so area scales with LANES rather than SIDE_SIZE. It sits between the round's nonlinear stage and the next layer in iterative SWAN64/128/256 datapaths. Because COLUMNS is even, rho is an involution, so the same unit serves encryption and decryption.

## Interface
- BLOCK_SIZE, 64: cipher block width; legal 64, 128, 256.
- COLUMNS, 4: columns per half-block; even, power of two, ≥2.
- LANES, COLUMNS: columns handled per cycle; power of two dividing COLUMNS.
- Derived: SIDE_SIZE = BLOCK_SIZE/2, COLUMN_SIZE = SIDE_SIZE/COLUMNS, K = COLUMNS/LANES.
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  x is valid.
- in_ready  out  1  unit can accept x this cycle.
- x  in  SIDE_SIZE  input half-block, MSB-first; column 0 = x[0:COLUMN_SIZE-1].
- out_valid  out  1  y is valid.
- out_ready  in  1  consumer accepts y.
- y  out  SIDE_SIZE  result, same column ordering as x.

## Operation
- States: IDLE, ACC, APPLY, DONE.
- IDLE: in_ready=1. On in_valid: latch x into buf, clear t_acc, col=0, go to ACC.
- ACC: t_acc ^= XOR of columns col..col+LANES-1 of buf; col += LANES. After the K-th cycle, col=0 and the FSM goes to APPLY.
- APPLY: buf columns col..col+LANES-1 ^= t_acc, in place; col += LANES. After the K-th cycle, go to DONE.
- DONE: out_valid=1, y=buf, and y is held stable until the handshake completes.
  - out_ready=1 and in_valid=0: go to IDLE.
  - out_ready=1 and in_valid=1: accept the new x in the same cycle (in_ready = out_ready in DONE), go to ACC.
  - out_ready=0: stay in DONE; in_ready=0.
- in_ready=0 in ACC and APPLY. x is ignored outside an accepting cycle.
- t_acc is COLUMN_SIZE bits wide. XOR is bitwise, with no carries and no width growth.
- Column counter col is clog2(COLUMNS) bits wide; it wraps to 0 on each phase change and is never compared against COLUMNS directly.

## Timing
- Reset (sync, rst=1 at an edge): state=IDLE, in_ready=1, out_valid=0, y=0 (buf cleared), t_acc=0, col=0. rst dominates every other input. Reset mid-ACC, mid-APPLY or in DONE discards the block in flight; no output is produced for it.
- The edge after reset deasserts, the unit is ready to accept.
- Latency: the input handshake at edge E0 gives out_valid=1 after edge E0+2K+1 (ACC K cycles, APPLY K cycles, then DONE).
  - LANES=COLUMNS: 3 cycles.
  - LANES=1, COLUMNS=4: 9 cycles.
- Throughput with out_ready held at 1: one block per 2K+1 cycles, because accept-in-DONE removes the IDLE bubble.
- in_ready and out_valid are registered-state decodes. in_ready in DONE combinationally depends on out_ready; no other input-to-output combinational path exists.

## Structure
- Shared package swan_rho_pkg holds:
  - derived-width functions for SIDE_SIZE, COLUMN_SIZE and K;
  - the FSM state encoding (2-bit localparams);
  - the legality checks on BLOCK_SIZE, COLUMNS and LANES, which fail elaboration when violated.
- One sub-module, rho_lane_xor: combinational XOR-reduce of LANES×COLUMN_SIZE bits to COLUMN_SIZE bits, instantiated once in ACC. The APPLY path is plain XOR in the top level.

## Test plan
- BLOCK_SIZE=64, COLUMNS=4, LANES=4; x=32'h1234_5678 → y=32'h1A3C_5E70 with out_valid 3 cycles after accept; feeding y back in returns 32'h1234_5678 (involution).
- Same x with LANES=1 → identical y with out_valid 9 cycles after accept; LANES=2 → 5 cycles.
- x=32'h0000_0001 → 32'h0101_0100; x=32'hFFFF_FFFF → 32'hFFFF_FFFF (t=0).
- Backpressure: out_ready=0 for 5 cycles in DONE → y stable, in_ready=0, no new input accepted. Then out_ready=1 with in_valid=1 → new block accepted on that same edge.
- rst=1 during APPLY (LANES=1) → the next cycle shows IDLE, out_valid=0, y=0. A following block with x=32'h1234_5678 yields 32'h1A3C_5E70, uncorrupted.
- BLOCK_SIZE=128, COLUMNS=8, LANES=2; random x vs golden model for 1000 blocks with random valid/ready → every output matches, and no block is dropped or duplicated.
